// File: rtl/exec_issue_sequencer_pkg.sv
// Shared definitions for the execute-side issue sequencer.
//   SHORT_LAT / LONG_LAT_MIN : latency bounds for short and long instructions
//   tag_t                    : default-width instruction tag
//   state_t                  : occupancy view (IDLE / RUN / LAST)
//   clamp_lat()              : effective execute latency of an issued instruction
package exec_pkg;

  localparam int unsigned SHORT_LAT     = 1;
  localparam int unsigned LONG_LAT_MIN  = 2;
  localparam int unsigned TAG_W_DEFAULT = 4;

  typedef logic [TAG_W_DEFAULT-1:0] tag_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,  // cnt == 0
    ST_RUN  = 2'd1,  // cnt >= 2
    ST_LAST = 2'd2   // cnt == 1, completing this cycle
  } state_t;

  // Short ops always take one cycle; long ops are held inside
  // [LONG_LAT_MIN, max_lat] so a bogus request can never stall forever
  // or collapse into a short op.
  function automatic int unsigned clamp_lat(input int unsigned lat,
                                            input logic        is_long,
                                            input int unsigned max_lat);
    if (!is_long) return SHORT_LAT;
    if (lat < LONG_LAT_MIN) return LONG_LAT_MIN;
    if (lat > max_lat) return max_lat;
    return lat;
  endfunction

endpackage

// File: rtl/exec_issue_sequencer_if.sv
// Issue / completion bundle between the instruction buffer, the execute
// sequencer and writeback.
//   master : buffer side - drives issue_*, flush; observes status/completion
//   slave  : sequencer side - the reverse
interface exec_issue_sequencer_if #(
  parameter int unsigned MAX_LAT = 8,
  parameter int unsigned TAG_W   = 4,
  parameter int unsigned RET_W   = 16
);
  localparam int unsigned LAT_W = $clog2(MAX_LAT + 1);

  logic             issue_valid;
  logic             issue_is_long;
  logic [LAT_W-1:0] issue_lat;
  logic [TAG_W-1:0] issue_tag;
  logic             flush;
  logic             exec_busy;
  logic             exec_will_free_next;
  logic             done_valid;
  logic [TAG_W-1:0] done_tag;
  logic             proto_err;
  logic [RET_W-1:0] retired;

  modport master (
    output issue_valid, issue_is_long, issue_lat, issue_tag, flush,
    input  exec_busy, exec_will_free_next, done_valid, done_tag,
           proto_err, retired
  );

  modport slave (
    input  issue_valid, issue_is_long, issue_lat, issue_tag, flush,
    output exec_busy, exec_will_free_next, done_valid, done_tag,
           proto_err, retired
  );

endinterface

// File: rtl/exec_issue_sequencer.sv
// Execute-side issue sequencer.
// Accepts instructions issued by the level-2 instruction buffer, tracks
// multi-cycle execute occupancy, returns exec_busy / exec_will_free_next to
// the buffer, pulses done_valid/done_tag on completion and counts retirements.
// Ports:
//   clk      : rising-edge clock
//   reset_n  : asynchronous active-low reset
//   bus      : exec_issue_sequencer_if.slave (issue, flush, status, completion,
//              proto_err, retired)
// Every output comes straight from a register.
module exec_issue_sequencer
  import exec_pkg::*;
#(
  parameter int unsigned MAX_LAT = 8,
  parameter int unsigned TAG_W   = 4,
  parameter int unsigned RET_W   = 16
) (
  input logic                   clk,
  input logic                   reset_n,
  exec_issue_sequencer_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(MAX_LAT + 1);

  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;
  logic [CNT_W-1:0] lat_eff;
  logic [TAG_W-1:0] cur_tag_reg;
  logic [TAG_W-1:0] cur_tag_next;
  state_t           state_reg;
  state_t           state_next;
  logic             proto_err_reg;
  logic [RET_W-1:0] retired_reg;
  logic             can_accept;
  logic             accept;
  logic             proto_hit;

  // A unit in its last cycle can take the next op, giving back-to-back issue.
  assign can_accept = (cnt_reg <= CNT_W'(1));
  assign accept     = bus.issue_valid & can_accept & ~bus.flush;
  // An issue during flush is silently dropped, not a protocol error.
  assign proto_hit  = bus.issue_valid & ~can_accept & ~bus.flush;
  assign lat_eff    = CNT_W'(clamp_lat(32'(bus.issue_lat), bus.issue_is_long, MAX_LAT));

  always_comb begin
    cnt_next     = cnt_reg;
    cur_tag_next = cur_tag_reg;
    if (bus.flush) begin
      cnt_next = '0;
    end else if (accept) begin
      cnt_next     = lat_eff;
      cur_tag_next = bus.issue_tag;
    end else if (cnt_reg != '0) begin
      cnt_next = cnt_reg - CNT_W'(1);
    end
  end

  always_comb begin
    state_next = ST_RUN;
    if (cnt_next == '0)
      state_next = ST_IDLE;
    else if (cnt_next == CNT_W'(1))
      state_next = ST_LAST;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_reg       <= '0;
      cur_tag_reg   <= '0;
      state_reg     <= ST_IDLE;
      proto_err_reg <= 1'b0;
      retired_reg   <= '0;
    end else begin
      cnt_reg     <= cnt_next;
      cur_tag_reg <= cur_tag_next;
      state_reg   <= state_next;
      if (proto_hit)
        proto_err_reg <= 1'b1;
      // The done pulse is already visible this cycle, so it retires even if
      // a flush arrives alongside it.
      if (state_reg == ST_LAST)
        retired_reg <= retired_reg + RET_W'(1);
    end
  end

  assign bus.exec_busy           = (state_reg != ST_IDLE);
  assign bus.exec_will_free_next = (state_reg == ST_LAST);
  assign bus.done_valid          = (state_reg == ST_LAST);
  assign bus.done_tag            = cur_tag_reg;
  assign bus.proto_err           = proto_err_reg;
  assign bus.retired             = retired_reg;

endmodule
